// File: rtl/adaptive_binarization.sv
// Luminance binariser with fixed, previous-frame-mean, or mean-with-hysteresis threshold.
// Optional feature macro BINARIZE_FRAME_STATS_EN adds the per-frame white_count output.
module adaptive_binarization #(
  parameter int DATA_W         = 8,
  parameter int OUT_W          = 24,
  parameter int CNT_W          = 22,
  parameter int HYST           = 4,
  parameter int INIT_THRESHOLD = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_vsync,
  input  logic              pre_clken,
  input  logic              pre_data_valid,
  input  logic [DATA_W-1:0] pre_luma,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_threshold,
  input  logic              cfg_invert,
  output logic              post_vsync,
  output logic              post_clken,
  output logic              post_data_valid,
  output logic [OUT_W-1:0]  post_data,
  output logic [DATA_W-1:0] cur_threshold,
  output logic              thr_update
`ifdef BINARIZE_FRAME_STATS_EN
  ,
  output logic [CNT_W-1:0]  white_count
`endif
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int BIT_W = $clog2(SUM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] LUMA_MAX = '1;
  localparam logic [DATA_W-1:0] HYST_N   = DATA_W'(HYST);
  localparam logic [DATA_W:0]   HYST_W   = (DATA_W+1)'(HYST);

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  state_t state, state_next;

  logic              boundary, pixel;
  logic [DATA_W-1:0] thr, thr_hi, thr_lo;
  logic [DATA_W:0]   thr_sum;
  logic              decision, out_bit, bit_q, hyst_q;

  logic [SUM_W-1:0]  sum, quo;
  logic [CNT_W-1:0]  cnt, divisor, rem, rem_next;
  logic [CNT_W:0]    rem_shift;
  logic              q_bit;
  logic [BIT_W-1:0]  bit_cnt;

  // post_vsync doubles as the previous-cycle vsync for edge detection.
  assign boundary  = pre_vsync & ~post_vsync;
  assign pixel     = pre_clken & pre_data_valid;
  assign post_data = {OUT_W{bit_q}};

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    thr      = (cfg_mode == 2'd1 || cfg_mode == 2'd2) ? cur_threshold : cfg_threshold;
    thr_sum  = {1'b0, thr} + HYST_W;
    thr_hi   = (thr_sum > {1'b0, LUMA_MAX}) ? LUMA_MAX : thr_sum[DATA_W-1:0];
    thr_lo   = (thr < HYST_N) ? '0 : thr - HYST_N;
    decision = pre_luma > thr;
    if (cfg_mode == 2'd2) begin
      if (pre_luma > thr_hi)      decision = 1'b1;
      else if (pre_luma < thr_lo) decision = 1'b0;
      else                        decision = hyst_q;
    end
    out_bit = decision ^ cfg_invert;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync      <= 1'b0;
      post_clken      <= 1'b0;
      post_data_valid <= 1'b0;
      bit_q           <= 1'b0;
      hyst_q          <= 1'b0;
    end else begin
      post_vsync      <= pre_vsync;
      post_clken      <= pre_clken;
      post_data_valid <= pre_data_valid;
      if (pre_clken) bit_q <= out_bit;
      if (post_data_valid && !pre_data_valid) hyst_q <= 1'b0;
      else if (pixel)                         hyst_q <= decision;
    end
  end

  // Frame statistics; a pixel coinciding with the boundary opens the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      cnt <= '0;
    end else if (boundary) begin
      sum <= pixel ? SUM_W'(pre_luma) : '0;
      cnt <= pixel ? CNT_W'(1) : '0;
    end else if (pixel && cnt != CNT_MAX) begin
      sum <= sum + SUM_W'(pre_luma);
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Restoring divider step: the dividend shifts out of quo MSB-first while quotient bits shift in.
  always_comb begin
    rem_shift = {rem, quo[SUM_W-1]};
    q_bit     = rem_shift >= {1'b0, divisor};
    rem_next  = q_bit ? rem_shift[CNT_W-1:0] - divisor : rem_shift[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (boundary) begin
      state_next = (cnt != '0) ? DIV : IDLE;
    end else begin
      unique case (state)
        DIV:     if (bit_cnt == '0) state_next = LOAD;
        LOAD:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo           <= '0;
      rem           <= '0;
      divisor       <= '0;
      bit_cnt       <= '0;
      cur_threshold <= DATA_W'(INIT_THRESHOLD);
      thr_update    <= 1'b0;
    end else begin
      thr_update <= 1'b0;
      if (boundary) begin
        quo     <= sum;
        divisor <= cnt;
        rem     <= '0;
        bit_cnt <= BIT_W'(SUM_W - 1);
      end else if (state == DIV) begin
        quo     <= {quo[SUM_W-2:0], q_bit};
        rem     <= rem_next;
        bit_cnt <= bit_cnt - BIT_W'(1);
      end else if (state == LOAD) begin
        cur_threshold <= (quo[SUM_W-1:DATA_W] != '0) ? LUMA_MAX : quo[DATA_W-1:0];
        thr_update    <= 1'b1;
      end
    end
  end

`ifdef BINARIZE_FRAME_STATS_EN
  logic [CNT_W-1:0] white_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      white_cnt   <= '0;
      white_count <= '0;
    end else if (boundary) begin
      white_count <= white_cnt;
      white_cnt   <= (pixel && out_bit) ? CNT_W'(1) : '0;
    end else if (pixel && out_bit && white_cnt != CNT_MAX) begin
      white_cnt <= white_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/adaptive_binarization.md
Name: adaptive_binarization

Overview:
Parametrised successor to the fixed-threshold binariser in the video processing chain, placed between the grayscale converter and the frame-buffer writer. It supports three modes:
- a fixed threshold,
- a threshold taken from the previous frame's mean luminance,
- the same mean threshold with a hysteresis band.

Per-frame statistics are accumulated on the fly. The mean is computed by a sequential divider between frames. Sync and enable signals pass through with 1-cycle latency.

Parameters:
DATA_W, 8, luminance width in bits.
OUT_W, 24, output pixel width; every bit replicates the binary decision.
CNT_W, 22, pixel counter width; the sum accumulator is DATA_W+CNT_W bits.
HYST, 4, half-width of the hysteresis band, in luminance LSBs.
INIT_THRESHOLD, 80, threshold value loaded at reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
pre_vsync  in  1  frame sync; a rising edge marks a frame boundary.
pre_clken  in  1  pixel clock enable.
pre_data_valid  in  1  pixel valid.
pre_luma  in  DATA_W  input luminance.
cfg_mode  in  2  0 = fixed, 1 = mean, 2 = mean + hysteresis, 3 = same as 0.
cfg_threshold  in  DATA_W  threshold used in mode 0/3.
cfg_invert  in  1  1 = invert the output decision.
post_vsync  out  1  pre_vsync delayed 1 cycle.
post_clken  out  1  pre_clken delayed 1 cycle.
post_data_valid  out  1  pre_data_valid delayed 1 cycle.
post_data  out  OUT_W  {OUT_W{bit}} where bit = decision XOR cfg_invert.
cur_threshold  out  DATA_W  threshold currently applied in modes 1/2.
thr_update  out  1  1-cycle pulse when cur_threshold is loaded.

Behaviour:
- Reset values: all outputs 0, except cur_threshold = INIT_THRESHOLD. Accumulators cleared; FSM in IDLE; hysteresis state 0.
- Data path: 1 register stage. post_* and post_data appear 1 cycle after inputs. post_data updates only when pre_clken=1; otherwise it holds.
- Threshold selection: T = cfg_threshold in modes 0/3, cur_threshold in modes 1/2. All comparisons unsigned.
- Modes 0/1/3: decision = (pre_luma > T).
- Mode 2:
  - decision = 1 if pre_luma > sat(T+HYST); 0 if pre_luma < sat(T−HYST); otherwise the previous decision.
  - sat() clamps to the range [0, 2^DATA_W−1].
  - Hysteresis state clears to 0 on a falling edge of pre_data_valid (end of line).
- Statistics:
  - On each cycle with pre_clken & pre_data_valid: sum += pre_luma, cnt += 1.
  - When cnt reaches 2^CNT_W−1, both sum and cnt freeze for the rest of the frame; no wrap.
- Frame boundary: detected as a rising edge of pre_vsync (registered compare, previous value 0, current value 1). In that cycle:
  - sum and cnt are latched into the divider operands.
  - The accumulators clear to 0. A valid pixel arriving in the same cycle is counted into the new frame.
- FSM states: IDLE, DIV, LOAD.
  - IDLE → DIV on a boundary with latched cnt ≠ 0.
  - On a boundary with latched cnt = 0, stay in IDLE; cur_threshold is unchanged and thr_update is not pulsed.
  - DIV: restoring division of sum by cnt, 1 quotient bit per cycle, DATA_W+CNT_W cycles.
  - DIV → LOAD when the bit counter expires.
  - LOAD: cur_threshold ← quotient, saturated to DATA_W bits. thr_update=1 for this 1 cycle. Then → IDLE.
- Boundary while in DIV or LOAD: the current division is abandoned and restarts immediately with the new operands. The abandoned result is never loaded.
- The divider runs and cur_threshold updates in every mode. The mode only selects which threshold is applied.
- cfg_* inputs are sampled every cycle; a change takes effect on the next pixel.
- Reset asserted mid-frame or mid-division returns everything to its reset values asynchronously.

Optional Feature:
Macro: BINARIZE_FRAME_STATS_EN.
- When defined:
  - Extra output port white_count, width CNT_W.
  - A counter increments on every valid output pixel whose final bit = 1, saturating at 2^CNT_W−1.
  - On a frame boundary, white_count ← counter and the counter clears to 0.
  - white_count resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Mode 0, cfg_threshold=80: luma 80 → post_data 0x000000; luma 81 → 0xFFFFFF, each 1 cycle later. post_vsync, post_clken and post_data_valid each delayed exactly 1 cycle.
2. Mode 1, frame of 4 pixels {10,20,30,40}, then vsync rising edge → thr_update pulses exactly DATA_W+CNT_W+1 cycles after the boundary; cur_threshold = 25. The next frame's luma 26 → 1, luma 25 → 0.
3. Mode 2, T=100, HYST=4: sequence 105,100,96,95,100 → 1,1,1,0,0. Drop pre_data_valid, then luma 100 → 0.
4. Frame with zero valid pixels → no thr_update; cur_threshold keeps its previous value. Second vsync edge 10 cycles after the first → only one thr_update, carrying the second frame's mean.
5. cfg_invert=1 in mode 0, T=80, luma 200 → post_data 0x000000. Assert rst mid-DIV → outputs 0, cur_threshold=80, no thr_update.
6. With BINARIZE_FRAME_STATS_EN: frame with 3 of 5 pixels above threshold → white_count = 3 after the next boundary.
